mmio_periph: RTL and testbench
==============================

# mmio_periph

Parametrised memory-mapped peripheral block for the multicycle MIPS SoC: the successor to the switch/LED/7-segment handling inside the data-memory module. Sits on the core's data-memory bus beside the RAM and claims one address window. Provides a debounced switch port, an LED register, a multiplexed hex 7-segment driver with N digits, and an auto-reload 32-bit timer with interrupt.

## Interface
- BASE_ADDR, 32'h4000_0000: window base; window is 32 bytes, word-aligned.
- SW_WIDTH, 8: switch input width (1..32).
- LED_WIDTH, 8: LED output width (1..32).
- NUM_DIGITS, 4: 7-segment digit count (1..8).
- SCAN_DIV, 50000: clocks per digit slot (>=2).
- DEBOUNCE, 1000: clocks a synchronised switch value must hold before it is accepted (>=1).
- iClk  in  1  clock, all state on rising edge.
- iRst_n  in  1  asynchronous, active-low reset.
- iRd / iWr  in  1  bus read / write strobes.
- iAddr  in  32  byte address; bits [1:0] ignored.
- iWrData  in  32  write data.
- oRdData  out  32  read data, combinational.
- oAccessable  out  1  high when iAddr is inside the window.
- iSwitch  in  SW_WIDTH  raw asynchronous switches.
- oLED  out  LED_WIDTH  LED register.
- oDigiAn  out  NUM_DIGITS  digit enables, active-low, one-hot-low.
- oDigiSeg  out  8  segments {dp,g..a}, active-low.
- oIrq  out  1  timer interrupt, level.

## Operation
- Register map (offset): 0x00 TH reload; 0x04 TL counter; 0x08 TCON {29'b0, status, irq_en, en}; 0x0C LED (low LED_WIDTH bits, rest read 0); 0x10 SW read-only (debounced, zero-extended); 0x14 DIGI nibbles, digit k = bits [4k+3:4k], unused bits read 0; 0x18 DP mask, bit k lights dp of digit k; 0x1C reads 0.
- oAccessable = iAddr[31:5] == BASE_ADDR[31:5]; strobes outside the window are ignored; oRdData = 0 when not accessable or iRd low.
- Writes occur on the iClk edge with iWr && oAccessable; writes to SW and 0x1C are no-ops. Unimplemented bits are write-ignored.
- Timer: when en=1, TL increments each clock; TL==32'hFFFF_FFFF -> next TL=TH, status<=1. oIrq = status & irq_en. Status clears only by TCON write with bit2=0; a write with bit2=1 leaves status unchanged (cannot set it by software).
- Same-cycle conflicts: bus write to TL wins over increment/reload; overflow in the same cycle as a TCON write clearing status leaves status=1 (hardware set wins).
- Switch path: 2-flop synchroniser per bit; counter restarts when synced value != candidate; when candidate has been stable DEBOUNCE consecutive clocks, SW register <= candidate.
- Display: prescaler counts 0..SCAN_DIV-1; on wrap, digit index advances 0..NUM_DIGITS-1, wrapping to 0. oDigiAn drives low only bit idx; oDigiSeg = ~{dp[idx], hex7seg(nibble[idx])}, standard hex glyphs 0-F.

## Timing
- Reset: TH=TL=0, TCON=0, LED=0, DIGI=0, DP=0, SW register=0, synchronisers/counters=0, digit idx=0 -> oLED=0, oIrq=0, oDigiAn=~1 (digit 0 on), oDigiSeg=8'hC0 (glyph '0', dp off). Reset mid-scan or mid-count returns all of this immediately.
- Read latency 0: oRdData reflects register contents before the current edge's write.
- Write-to-output latency 1 clock (oLED, display, oIrq).
- Timer: overflow at edge n -> status and oIrq high after edge n.
- Switch change -> SW register update after 2 sync + DEBOUNCE clocks of stability.
- Digit slot length exactly SCAN_DIV clocks; full refresh NUM_DIGITS*SCAN_DIV.

## Test plan
- Reset with all inputs toggling -> oLED=0, oIrq=0, oDigiAn=4'b1110, oDigiSeg=8'hC0; reads of 0x00-0x18 all 0.
- Write LED=32'h0000_01A5 at 0x4000_000C -> oLED=8'hA5 next cycle; read back 32'h0000_00A5; write to 0x4000_0020 -> oAccessable=0, oLED unchanged.
- TH=32'hFFFF_FFF0, TL=32'hFFFF_FFFD, TCON=3 -> oIrq rises 3 clocks later, TL=FFFF_FFF0 after wrap; TCON=3 clears, oIrq low next cycle; overflow coinciding with clear -> status stays 1.
- DEBOUNCE=4: iSwitch 8'h00->8'h3C with 2-clock glitch first -> SW stays 0 during glitch; reads 32'h3C exactly 2+4 clocks after stable edge.
- SCAN_DIV=3, NUM_DIGITS=4, DIGI=16'h1F8A, DP=4'b0100 -> sequence An 1110/1101/1011/0111, Seg 8'h88('A'), 8'h80('8'), 8'h0E('F'+dp), 8'hF9('1'), each 3 clocks, then wraps.
- Simultaneous TL write 32'h5 with timer enabled -> TL reads 5 next cycle, 6 the cycle after.

Source files
------------

// File: rtl/mmio_periph.sv
`timescale 1ns/1ps
// Memory-mapped peripheral window for the multicycle MIPS SoC: debounced switches, LED
// register, multiplexed hex 7-segment display and an auto-reload 32-bit timer with interrupt.
module mmio_periph #(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int          SW_WIDTH   = 8,
  parameter int          LED_WIDTH  = 8,
  parameter int          NUM_DIGITS = 4,
  parameter int          SCAN_DIV   = 50000,
  parameter int          DEBOUNCE   = 1000
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iRd,
  input  logic                  iWr,
  input  logic [31:0]           iAddr,
  input  logic [31:0]           iWrData,
  output logic [31:0]           oRdData,
  output logic                  oAccessable,
  input  logic [SW_WIDTH-1:0]   iSwitch,
  output logic [LED_WIDTH-1:0]  oLED,
  output logic [NUM_DIGITS-1:0] oDigiAn,
  output logic [7:0]            oDigiSeg,
  output logic                  oIrq
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DEB_W  = $clog2(DEBOUNCE + 1);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE);

  localparam logic [2:0] REG_TH   = 3'd0;
  localparam logic [2:0] REG_TL   = 3'd1;
  localparam logic [2:0] REG_TCON = 3'd2;
  localparam logic [2:0] REG_LED  = 3'd3;
  localparam logic [2:0] REG_SW   = 3'd4;
  localparam logic [2:0] REG_DIGI = 3'd5;
  localparam logic [2:0] REG_DP   = 3'd6;

  logic [31:0]             th, tl;
  logic                    tcEn, irqEn, status;
  logic [LED_WIDTH-1:0]    led;
  logic [4*NUM_DIGITS-1:0] digi;
  logic [NUM_DIGITS-1:0]   dpMask;
  logic [SW_WIDTH-1:0]     sync1, sync2, cand, swReg;
  logic [DEB_W-1:0]        debCnt;
  logic [SCAN_W-1:0]       presc;
  logic [IDX_W-1:0]        digIdx;

  logic [2:0] regSel;
  logic       wrEn, overflow, dpBit, addrLsbUnused;
  logic [3:0] nibble;

  assign oAccessable   = (iAddr[31:5] == BASE_ADDR[31:5]);
  assign regSel        = iAddr[4:2];
  assign wrEn          = iWr & oAccessable;
  assign overflow      = tcEn & (tl == 32'hFFFF_FFFF);
  assign addrLsbUnused = ^iAddr[1:0];

  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    case (v)
      4'h0: hex7seg = 7'h3F;  4'h1: hex7seg = 7'h06;
      4'h2: hex7seg = 7'h5B;  4'h3: hex7seg = 7'h4F;
      4'h4: hex7seg = 7'h66;  4'h5: hex7seg = 7'h6D;
      4'h6: hex7seg = 7'h7D;  4'h7: hex7seg = 7'h07;
      4'h8: hex7seg = 7'h7F;  4'h9: hex7seg = 7'h6F;
      4'hA: hex7seg = 7'h77;  4'hB: hex7seg = 7'h7C;
      4'hC: hex7seg = 7'h39;  4'hD: hex7seg = 7'h5E;
      4'hE: hex7seg = 7'h79;  default: hex7seg = 7'h71;
    endcase
  endfunction

  // NOTE: state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      th     <= '0;
      tl     <= '0;
      tcEn   <= 1'b0;
      irqEn  <= 1'b0;
      status <= 1'b0;
    end else begin
      if (wrEn && regSel == REG_TH) th <= iWrData;
      if (wrEn && regSel == REG_TL) tl <= iWrData;
      else if (tcEn)                tl <= overflow ? th : tl + 32'd1;
      if (wrEn && regSel == REG_TCON) begin
        tcEn  <= iWrData[0];
        irqEn <= iWrData[1];
      end
      // A hardware overflow outranks a software clear landing on the same edge.
      if (overflow)                                          status <= 1'b1;
      else if (wrEn && regSel == REG_TCON && !iWrData[2])    status <= 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      led    <= '0;
      digi   <= '0;
      dpMask <= '0;
    end else if (wrEn) begin
      case (regSel)
        REG_LED:  led    <= iWrData[LED_WIDTH-1:0];
        REG_DIGI: digi   <= iWrData[4*NUM_DIGITS-1:0];
        REG_DP:   dpMask <= iWrData[NUM_DIGITS-1:0];
        default:  ;
      endcase
    end
  end

  // debCnt counts consecutive clocks the synchronised value has matched cand.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      cand   <= '0;
      swReg  <= '0;
      debCnt <= '0;
    end else begin
      sync1 <= iSwitch;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand   <= sync2;
        debCnt <= DEB_W'(1);
        if (DEBOUNCE == 1) swReg <= sync2;
      end else if (debCnt != DEB_MAX) begin
        debCnt <= debCnt + DEB_W'(1);
        if (debCnt == DEB_MAX - DEB_W'(1)) swReg <= cand;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      presc  <= '0;
      digIdx <= '0;
    end else if (presc == SCAN_LAST) begin
      presc  <= '0;
      digIdx <= (digIdx == IDX_LAST) ? '0 : digIdx + IDX_W'(1);
    end else begin
      presc <= presc + SCAN_W'(1);
    end
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    oRdData = '0;
    if (iRd && oAccessable) begin
      case (regSel)
        REG_TH:   oRdData = th;
        REG_TL:   oRdData = tl;
        REG_TCON: oRdData = {29'b0, status, irqEn, tcEn};
        REG_LED:  oRdData = 32'(led);
        REG_SW:   oRdData = 32'(swReg);
        REG_DIGI: oRdData = 32'(digi);
        REG_DP:   oRdData = 32'(dpMask);
        default:  oRdData = '0;
      endcase
    end
  end

  assign nibble   = 4'(digi >> {digIdx, 2'b00});
  assign dpBit    = 1'(dpMask >> digIdx);
  assign oDigiAn  = ~(NUM_DIGITS'(1) << digIdx);
  assign oDigiSeg = ~{dpBit, hex7seg(nibble)};
  assign oLED     = led;
  assign oIrq     = status & irqEn;

endmodule

// File: tb/tb_mmio_periph.sv
`timescale 1ns/1ps
// Self-checking bench for mmio_periph: directed register/timer/switch/display steps plus a
// randomized bus and switch phase scored against a register-level reference model.
module tb_mmio_periph;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int SD  = 3;
  localparam int ND  = 4;
  localparam int DEB = 4;

  logic        iClk = 1'b0;
  logic        iRst_n, iRd, iWr;
  logic [31:0] iAddr, iWrData, oRdData;
  logic        oAccessable, oIrq;
  logic [7:0]  iSwitch, oLED, oDigiSeg;
  logic [3:0]  oDigiAn;

  mmio_periph #(
    .BASE_ADDR(BASE), .SW_WIDTH(8), .LED_WIDTH(8), .NUM_DIGITS(ND),
    .SCAN_DIV(SD), .DEBOUNCE(DEB)
  ) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iRd(iRd), .iWr(iWr), .iAddr(iAddr),
    .iWrData(iWrData), .oRdData(oRdData), .oAccessable(oAccessable),
    .iSwitch(iSwitch), .oLED(oLED), .oDigiAn(oDigiAn), .oDigiSeg(oDigiSeg),
    .oIrq(oIrq)
  );

  always #5 iClk = ~iClk;

  int nChecks = 0;
  int nErrors = 0;

  // Reference model state: register contents as seen after the latest edge.
  logic [31:0] thM, tlM;
  logic        enM, ieM, stM;
  logic [7:0]  ledM, swM;
  logic [15:0] digiM;
  logic [3:0]  dpM;
  int          edgeCnt;
  logic [7:0]  rawQ[$];
  logic [7:0]  stQ[$];
  logic [31:0] rdV;

  logic [3:0] anTab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [7:0] segTab [4] = '{8'h88, 8'h80, 8'h0E, 8'hF9};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic [31:0] readExp(input logic [31:0] a);
    if (a[31:5] != BASE[31:5]) return 32'h0;
    case (a[4:2])
      3'd0:    return thM;
      3'd1:    return tlM;
      3'd2:    return {29'b0, stM, ieM, enM};
      3'd3:    return {24'b0, ledM};
      3'd4:    return {24'b0, swM};
      3'd5:    return {16'b0, digiM};
      3'd6:    return {28'b0, dpM};
      default: return 32'h0;
    endcase
  endfunction

  task automatic modelReset();
    thM = '0; tlM = '0; enM = 0; ieM = 0; stM = 0;
    ledM = '0; swM = '0; digiM = '0; dpM = '0; edgeCnt = 0;
    rawQ.delete(); stQ.delete();
    rawQ.push_back(8'h00);
    rawQ.push_back(8'h00);
  endtask

  // Applies one rising edge to the model using the inputs driven before that edge.
  task automatic modelEdge();
    logic       wrHit, ov, ok;
    logic [2:0] off;
    logic [7:0] s;
    if (!iRst_n) begin
      modelReset();
      return;
    end
    wrHit = iWr && (iAddr[31:5] == BASE[31:5]);
    off   = iAddr[4:2];
    ov    = enM && (tlM == 32'hFFFF_FFFF);
    if (wrHit && off == 3'd1) tlM = iWrData;
    else if (ov)              tlM = thM;
    else if (enM)             tlM = tlM + 32'd1;
    if (ov) stM = 1'b1;
    else if (wrHit && off == 3'd2 && !iWrData[2]) stM = 1'b0;
    if (wrHit) begin
      case (off)
        3'd0: thM = iWrData;
        3'd2: begin enM = iWrData[0]; ieM = iWrData[1]; end
        3'd3: ledM = iWrData[7:0];
        3'd5: digiM = iWrData[15:0];
        3'd6: dpM = iWrData[3:0];
        default: ;
      endcase
    end
    // A switch value is accepted once its two-clock-delayed copy held DEB edges in a row.
    rawQ.push_back(iSwitch);
    s = rawQ.pop_front();
    stQ.push_back(s);
    if (stQ.size() > DEB) void'(stQ.pop_front());
    if (stQ.size() == DEB) begin
      ok = 1'b1;
      foreach (stQ[i]) if (stQ[i] != s) ok = 1'b0;
      if (ok) swM = s;
    end
    edgeCnt++;
  endtask

  task automatic checkOutputs();
    int         idx;
    logic [3:0] anE;
    logic [7:0] segE;
    idx  = (edgeCnt / SD) % ND;
    anE  = ~(4'b0001 << idx);
    segE = ~{dpM[idx], glyph(4'(digiM >> (idx * 4)))};
    check("led", oLED, ledM);
    check("irq", oIrq, stM & ieM);
    check("digi_an", oDigiAn, anE);
    check("digi_seg", oDigiSeg, segE);
  endtask

  task automatic step();
    @(posedge iClk);
    modelEdge();
    #1;
    checkOutputs();
  endtask

  task automatic rdBus(input logic [31:0] a, output logic [31:0] d);
    iRd = 1'b1;
    iAddr = a;
    #1;
    d = oRdData;
    iRd = 1'b0;
  endtask

  task automatic rdCheck(input logic [31:0] a);
    logic [31:0] d;
    rdBus(a, d);
    check($sformatf("rd_%h", a), d, readExp(a));
    check("accessable", oAccessable, a[31:5] == BASE[31:5]);
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    iWr = 1'b1;
    iAddr = a;
    iWrData = d;
    step();
    iWr = 1'b0;
  endtask

  function automatic logic [31:0] randAddr();
    if ($urandom_range(0, 9) == 0) return BASE + 32'd32 + 32'($urandom_range(0, 255));
    return BASE + 32'($urandom_range(0, 31));
  endfunction

  function automatic logic [31:0] randData(input logic [31:0] a);
    case (a[4:2])
      3'd0, 3'd1: return $urandom_range(0, 1) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                              : 32'($urandom);
      3'd2:       return 32'($urandom_range(0, 7));
      default:    return 32'($urandom);
    endcase
  endfunction

  function automatic logic [7:0] randSwitch();
    case ($urandom_range(0, 3))
      0:       return 8'h00;
      1:       return 8'h3C;
      2:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    logic found;
    iRst_n = 1'b0; iRd = 1'b0; iWr = 1'b0; iAddr = '0; iWrData = '0; iSwitch = '0;
    modelReset();

    // Reset held while every input toggles.
    for (int i = 0; i < 6; i++) begin
      iRd = 1'($urandom); iWr = 1'($urandom); iAddr = BASE + 32'($urandom_range(0, 31));
      iWrData = $urandom; iSwitch = 8'($urandom);
      step();
    end
    iWr = 1'b0;
    check("rst_led", oLED, 8'h00);
    check("rst_irq", oIrq, 1'b0);
    check("rst_an", oDigiAn, 4'b1110);
    check("rst_seg", oDigiSeg, 8'hC0);
    for (int k = 0; k < 7; k++) begin
      rdBus(BASE + 32'(k * 4), rdV);
      check($sformatf("rst_rd_%0d", k * 4), rdV, 32'h0);
    end
    iSwitch = 8'h00;
    iRst_n = 1'b1;
    step();

    // Switch glitch of two clocks is rejected; a stable change lands after 2 + DEB edges.
    iSwitch = 8'h3C;
    step(); step();
    iSwitch = 8'h00;
    for (int i = 0; i < 8; i++) begin
      step();
      rdBus(BASE + 32'h10, rdV);
      check("sw_glitch", rdV, 32'h0);
    end
    iSwitch = 8'h3C;
    for (int k = 1; k <= 6; k++) begin
      step();
      rdBus(BASE + 32'h10, rdV);
      check($sformatf("sw_stable_%0d", k), rdV, (k < 6) ? 32'h0 : 32'h3C);
      rdCheck(BASE + 32'h10);
    end

    // LED register and an out-of-window write.
    busWrite(BASE + 32'h0C, 32'h0000_01A5);
    check("led_write", oLED, 8'hA5);
    rdBus(BASE + 32'h0C, rdV);
    check("led_readback", rdV, 32'h0000_00A5);
    iWr = 1'b1; iAddr = BASE + 32'h20; iWrData = 32'h0000_00FF;
    #1;
    check("outside_accessable", oAccessable, 1'b0);
    step();
    iWr = 1'b0;
    check("outside_led_kept", oLED, 8'hA5);

    // Timer overflow, reload, software clear and clear colliding with overflow.
    busWrite(BASE + 32'h00, 32'hFFFF_FFF0);
    busWrite(BASE + 32'h04, 32'hFFFF_FFFD);
    busWrite(BASE + 32'h08, 32'h0000_0003);
    step(); step();
    check("irq_before_ovf", oIrq, 1'b0);
    step();
    check("irq_after_ovf", oIrq, 1'b1);
    rdBus(BASE + 32'h04, rdV);
    check("tl_reloaded", rdV, 32'hFFFF_FFF0);
    busWrite(BASE + 32'h08, 32'h0000_0003);
    check("irq_cleared", oIrq, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      rdBus(BASE + 32'h04, rdV);
      if (rdV == 32'hFFFF_FFFF) found = 1'b1;
      else step();
    end
    check("tl_reach_max", found, 1'b1);
    busWrite(BASE + 32'h08, 32'h0000_0003);
    check("irq_hw_set_wins", oIrq, 1'b1);
    rdBus(BASE + 32'h08, rdV);
    check("tcon_status_kept", rdV, 32'h7);
    busWrite(BASE + 32'h04, 32'h0000_0005);
    rdBus(BASE + 32'h04, rdV);
    check("tl_write_wins", rdV, 32'h5);
    step();
    rdBus(BASE + 32'h04, rdV);
    check("tl_incr_after_write", rdV, 32'h6);
    busWrite(BASE + 32'h08, 32'h0000_0000);
    check("irq_off", oIrq, 1'b0);
    busWrite(BASE + 32'h08, 32'h0000_0004);
    rdBus(BASE + 32'h08, rdV);
    check("status_not_sw_settable", rdV, 32'h0);

    // Display scan of 1F8A with dp on digit 2.
    busWrite(BASE + 32'h14, 32'h0000_1F8A);
    busWrite(BASE + 32'h18, 32'h0000_0004);
    for (int i = 0; i < 4 * ND * SD; i++) begin
      step();
      check("scan_an", oDigiAn, anTab[(edgeCnt / SD) % ND]);
      check("scan_seg", oDigiSeg, segTab[(edgeCnt / SD) % ND]);
    end

    // Randomized bus traffic and switch activity.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 1) rdCheck(randAddr());
      if ($urandom_range(0, 2) == 0) begin
        iWr = 1'b1;
        iAddr = randAddr();
        iWrData = randData(iAddr);
      end
      if ($urandom_range(0, 5) == 0) iSwitch = randSwitch();
      step();
      iWr = 1'b0;
    end

    // Reset mid-scan and mid-count takes effect at once.
    iRst_n = 1'b0;
    modelReset();
    #1;
    checkOutputs();
    for (int k = 0; k < 7; k++) begin
      rdBus(BASE + 32'(k * 4), rdV);
      check($sformatf("midrst_rd_%0d", k * 4), rdV, 32'h0);
    end
    step(); step();
    iRst_n = 1'b1;
    for (int i = 0; i < 8; i++) step();

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
